// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder: FSM state, default sizes,
// and the bit-counter width helper.
package spi_pkg;
  typedef enum logic {IDLE, SHIFT} spi_state_e;

  localparam int SPI_DATA_W_DEF = 8;
  localparam int SPI_SYNC_DEF   = 2;

  function automatic int spi_cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/spi_slave_core_if.sv
// SPI pins plus TX/RX word streams and status of the SPI responder.
// The slave modport is the core's view; master is the link/stream side.
interface spi_slave_core_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              tx_underrun;
  logic              rx_overrun;
  logic              frame_abort;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ready,
    output spi_miso, tx_ready, rx_data, rx_valid, busy,
           tx_underrun, rx_overrun, frame_abort
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ready,
    input  spi_miso, tx_ready, rx_data, rx_valid, busy,
           tx_underrun, rx_overrun, frame_abort
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Synchroniser chain for one asynchronous input, with 1-cycle rise/fall strobes
// taken between the last stage and one extra delay flop.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              dly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      dly   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~dly;
  assign fall = ~q & dly;
endmodule

// File: rtl/spi_slave_core.sv
// Mode-0 SPI responder on the system clock: oversampled SCLK/CS_N/MOSI,
// MSB-first shift registers, valid/ready TX and RX word streams, status pulses.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEF,
  parameter int SYNC_STAGES = SPI_SYNC_DEF
) (
  input logic             s_axi_aclk,
  input logic             s_axi_aresetn,
  spi_slave_core_if.slave bus
);
  localparam int                CNT_W    = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .d(bus.spi_sclk),
    .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(s_axi_aclk), .rst_n(s_axi_aresetn), .d(bus.spi_cs_n),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  // Same depth as the SCLK chain so mosi_s lines up with sclk_rise.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) mosi_chain <= '0;
    else                mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], bus.spi_mosi};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              miso;
  logic              tx_ready;
  logic              skip_shift;
  logic              tx_underrun, rx_overrun, frame_abort;

  assign rx_next = {rx_shift, mosi_s};

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      miso        <= 1'b0;
      tx_ready    <= 1'b0;
      skip_shift  <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_abort <= 1'b0;

      // Load slot; after a word completion MISO waits for the next SCLK fall.
      if (tx_ready) begin
        if (bus.tx_valid) tx_shift <= bus.tx_data;
        else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
        if (!skip_shift) miso <= bus.tx_valid & bus.tx_data[DATA_W-1];
      end

      if (rx_valid && bus.rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state      <= SHIFT;
            tx_ready   <= 1'b1;
            bit_cnt    <= '0;
            skip_shift <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state      <= IDLE;
            miso       <= 1'b0;
            bit_cnt    <= '0;
            skip_shift <= 1'b0;
            if (bit_cnt != '0) frame_abort <= 1'b1;
          end else begin
            if (sclk_rise && sclk_s) begin
              rx_shift <= rx_next[DATA_W-2:0];
              if (bit_cnt == CNT_LAST) begin
                rx_data    <= rx_next;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~bus.rx_ready;
                bit_cnt    <= '0;
                tx_ready   <= 1'b1;
                skip_shift <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (sclk_fall) begin
              if (skip_shift) begin
                miso       <= tx_shift[DATA_W-1];
                skip_shift <= 1'b0;
              end else begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                miso     <= tx_shift[DATA_W-2];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_miso    = miso;
  assign bus.tx_ready    = tx_ready;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.busy        = ~cs_s;
  assign bus.tx_underrun = tx_underrun;
  assign bus.rx_overrun  = rx_overrun;
  assign bus.frame_abort = frame_abort;
endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: mode-0 SPI master model at 1/100 of aclk, TX feeder queue,
// pulse counters and accepted-RX log, all checked against hand-computed values.
module tb_spi_slave_core;
  localparam int W    = 8;
  localparam int HALF = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_core_if #(.DATA_W(W)) bus ();

  spi_slave_core #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .bus(bus)
  );

  int n_tot = 0, n_bad = 0;
  int n_rdy = 0, n_cons = 0, n_ur = 0, n_ov = 0, n_ab = 0;
  int snap_rdy = 0, snap_ur = 0;
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  logic [W-1:0] mo[4];
  logic [W-1:0] mi[4];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.tx_ready) n_rdy++;
    if (bus.tx_ready && bus.tx_valid) n_cons++;
    if (bus.tx_underrun) n_ur++;
    if (bus.rx_overrun) n_ov++;
    if (bus.frame_abort) n_ab++;
    if (bus.rx_valid && bus.rx_ready) rxq.push_back(bus.rx_data);
  end

  // TX source: presents the queue head, drops valid once the slot consumed it.
  initial begin : feeder
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.tx_ready) begin
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
      end
      if (!bus.tx_valid && txq.size() > 0) begin
        bus.tx_data  = txq.pop_front();
        bus.tx_valid = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  task automatic set_rx_ready(input logic v);
    @(posedge clk); #1;
    bus.rx_ready = v;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Mode-0 frame of nbits bits from mo[]; MISO captured into mi[] on each rise.
  // rst_at >= 0 pulses reset before that bit and ends the frame there.
  task automatic spi_frame(input int nbits, input int rst_at);
    bus.spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      int w, b;
      w = i / W;
      b = W - 1 - (i % W);
      bus.spi_mosi = mo[w][b];
      #HALF;
      if (i == rst_at) begin
        pulse_reset();
        break;
      end
      if (i == nbits - 1) begin
        snap_rdy = n_rdy;
        snap_ur  = n_ur;
      end
      bus.spi_sclk = 1'b1;
      mi[w][b] = bus.spi_miso;
      #HALF;
      bus.spi_sclk = 1'b0;
    end
    #HALF;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    #HALF;
  endtask

  int r0, c0, u0, o0, a0, q0;

  initial begin : main
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin mo[i] = '0; mi[i] = '0; end

    // 1: reset held with SCLK toggling
    repeat (5) begin @(posedge clk); #1 bus.spi_sclk = ~bus.spi_sclk; end
    @(negedge clk);
    chk("rst_miso", bus.spi_miso, 0);
    chk("rst_tx_ready", bus.tx_ready, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pulses", {bus.tx_underrun, bus.rx_overrun, bus.frame_abort}, 0);
    chk("rst_rdy_cnt", n_rdy, 0);
    bus.spi_sclk = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // 2: single word, RX held until accepted
    txq.push_back(8'hA5);
    repeat (5) @(posedge clk);
    r0 = n_rdy; c0 = n_cons; q0 = rxq.size();
    mo[0] = 8'h55;
    spi_frame(8, -1);
    chk("t2_miso_word", mi[0], 8'hA5);
    chk("t2_rdy_at_cs", snap_rdy - r0, 1);
    chk("t2_consumed", n_cons - c0, 1);
    chk("t2_rx_valid", bus.rx_valid, 1);
    chk("t2_rx_data", bus.rx_data, 8'h55);
    repeat (20) @(negedge clk);
    chk("t2_rx_hold", bus.rx_valid, 1);
    set_rx_ready(1'b1);
    repeat (3) @(negedge clk);
    chk("t2_rx_clear", bus.rx_valid, 0);
    chk("t2_rx_accepts", rxq.size() - q0, 1);
    if (rxq.size() > q0) chk("t2_rx_word", rxq[q0], 8'h55);

    // 3: back-to-back words in one frame
    txq.push_back(8'h3C);
    txq.push_back(8'hC3);
    repeat (5) @(posedge clk);
    c0 = n_cons; q0 = rxq.size();
    mo[0] = 8'h01; mo[1] = 8'h80;
    spi_frame(16, -1);
    chk("t3_miso_w0", mi[0], 8'h3C);
    chk("t3_miso_w1", mi[1], 8'hC3);
    chk("t3_consumed", n_cons - c0, 2);
    chk("t3_rx_count", rxq.size() - q0, 2);
    if (rxq.size() >= q0 + 2) begin
      chk("t3_rx_w0", rxq[q0], 8'h01);
      chk("t3_rx_w1", rxq[q0+1], 8'h80);
    end

    // 4: underrun with no TX word available
    u0 = n_ur; q0 = rxq.size();
    mo[0] = 8'hFF;
    spi_frame(8, -1);
    chk("t4_miso_zero", mi[0], 8'h00);
    chk("t4_underrun", snap_ur - u0, 1);
    chk("t4_rx_data", bus.rx_data, 8'hFF);
    chk("t4_rx_count", rxq.size() - q0, 1);

    // 5: overrun with consumer stalled
    set_rx_ready(1'b0);
    o0 = n_ov;
    mo[0] = 8'h11; mo[1] = 8'h22;
    spi_frame(16, -1);
    chk("t5_overrun", n_ov - o0, 1);
    chk("t5_rx_data", bus.rx_data, 8'h22);
    chk("t5_rx_valid", bus.rx_valid, 1);
    set_rx_ready(1'b1);
    repeat (3) @(negedge clk);
    chk("t5_rx_clear", bus.rx_valid, 0);

    // 6: abort after 4 SCLKs, then recovery
    a0 = n_ab; q0 = rxq.size();
    mo[0] = 8'hF0;
    spi_frame(4, -1);
    chk("t6_abort", n_ab - a0, 1);
    chk("t6_abort_no_rx", rxq.size() - q0, 0);
    chk("t6_abort_rx_valid", bus.rx_valid, 0);
    mo[0] = 8'h5A;
    spi_frame(8, -1);
    chk("t6_recover_cnt", rxq.size() - q0, 1);
    if (rxq.size() > q0) chk("t6_recover_rx", rxq[q0], 8'h5A);
    chk("t6_no_extra_abort", n_ab - a0, 1);

    // 6b: reset pulsed mid-frame, then a clean frame
    a0 = n_ab; q0 = rxq.size();
    mo[0] = 8'hC3;
    spi_frame(8, 3);
    chk("t6r_no_abort", n_ab - a0, 0);
    chk("t6r_no_rx", rxq.size() - q0, 0);
    chk("t6r_rx_valid", bus.rx_valid, 0);
    chk("t6r_busy", bus.busy, 0);
    txq.push_back(8'h96);
    repeat (5) @(posedge clk);
    mo[0] = 8'h5A;
    spi_frame(8, -1);
    chk("t6r_miso", mi[0], 8'h96);
    chk("t6r_rx_cnt", rxq.size() - q0, 1);
    if (rxq.size() > q0) chk("t6r_rx", rxq[q0], 8'h5A);
    chk("t6r_abort_after", n_ab - a0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
